// File: rtl/cordic_controller.sv
// Purpose : Iteration controller for the combinational single-step cordic core.
//           Accepts a job, steps the core once per cycle, then returns x/y/z and overflow info.
// Latency : Job accept to o_res_valid is count+1 cycles. count=0 gives 1 cycle.
// Backpressure: The result is held stable until i_res_ready. o_job_ready stays low from accept
//           until the cycle after the result handshake, so only one job is in flight.
// Ports   : clk/rst_n (async active-low); i_job_* / o_job_ready carry the job in;
//           o_core_* drive the core, i_core_* return its next state and overflow flags;
//           o_res_* / o_res_valid / i_res_ready carry the result out.
// Option  : CORDIC_CTRL_OV_STOP_EN - stop at the first overflowing step and keep the pre-step state.
module cordic_controller #(
   parameter int p_WIDTH      = 32,
   parameter int p_ITER_WIDTH = 5,
   parameter int p_MAX_ITER   = 30
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_job_valid,
   output logic                    o_job_ready,
   input  logic [p_WIDTH-1:0]      i_job_x,
   input  logic [p_WIDTH-1:0]      i_job_y,
   input  logic [p_WIDTH-1:0]      i_job_z,
   input  logic                    i_job_system,
   input  logic                    i_job_mode,
   input  logic [p_ITER_WIDTH-1:0] i_job_num_iter,
   output logic [p_WIDTH-1:0]      o_core_x,
   output logic [p_WIDTH-1:0]      o_core_y,
   output logic [p_WIDTH-1:0]      o_core_z,
   output logic [p_ITER_WIDTH-1:0] o_core_iter,
   output logic                    o_core_system,
   output logic                    o_core_mode,
   input  logic [p_WIDTH-1:0]      i_core_x,
   input  logic [p_WIDTH-1:0]      i_core_y,
   input  logic [p_WIDTH-1:0]      i_core_z,
   input  logic                    i_core_x_ov,
   input  logic                    i_core_y_ov,
   input  logic                    i_core_z_ov,
   output logic                    o_res_valid,
   input  logic                    i_res_ready,
   output logic [p_WIDTH-1:0]      o_res_x,
   output logic [p_WIDTH-1:0]      o_res_y,
   output logic [p_WIDTH-1:0]      o_res_z,
   output logic [2:0]              o_res_ov,
   output logic [p_ITER_WIDTH:0]   o_res_ov_iter
);

   // The iteration counter must never wrap.
   if (p_MAX_ITER >= (2 ** p_ITER_WIDTH) || p_MAX_ITER < 1) begin : g_bad_max_iter
      $error("cordic_controller: p_MAX_ITER must be in 1 .. 2**p_ITER_WIDTH-1");
   end

   localparam logic [p_ITER_WIDTH-1:0] c_MAX_ITER = p_ITER_WIDTH'(p_MAX_ITER);
   localparam logic [p_ITER_WIDTH-1:0] c_ITER_ONE = p_ITER_WIDTH'(1);
   localparam logic [p_ITER_WIDTH:0]   c_NO_OV    = '1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                  state_q;
   logic [p_WIDTH-1:0]      x_q, y_q, z_q;
   logic                    system_q, mode_q;
   logic [p_ITER_WIDTH-1:0] iter_q, cnt_q;
   logic [2:0]              ov_q;
   logic [p_ITER_WIDTH:0]   ov_iter_q;
   logic                    job_ready_q, res_valid_q;

   logic [p_ITER_WIDTH-1:0] job_cnt;
   logic [p_ITER_WIDTH-1:0] iter_nxt;
   logic                    last_step;
   logic [2:0]              core_ov;
   logic                    any_ov;

   assign job_cnt   = (i_job_num_iter > c_MAX_ITER) ? c_MAX_ITER : i_job_num_iter;
   // iter < count <= p_MAX_ITER, so iter+1 cannot wrap.
   assign iter_nxt  = iter_q + c_ITER_ONE;
   assign last_step = (iter_nxt == cnt_q);
   assign core_ov   = {i_core_x_ov, i_core_y_ov, i_core_z_ov};
   assign any_ov    = |core_ov;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         x_q         <= '0;
         y_q         <= '0;
         z_q         <= '0;
         system_q    <= 1'b0;
         mode_q      <= 1'b0;
         iter_q      <= '0;
         cnt_q       <= '0;
         ov_q        <= '0;
         ov_iter_q   <= c_NO_OV;
         job_ready_q <= 1'b1;
         res_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (i_job_valid) begin
                  x_q         <= i_job_x;
                  y_q         <= i_job_y;
                  z_q         <= i_job_z;
                  system_q    <= i_job_system;
                  mode_q      <= i_job_mode;
                  cnt_q       <= job_cnt;
                  iter_q      <= '0;
                  ov_q        <= '0;
                  ov_iter_q   <= c_NO_OV;
                  job_ready_q <= 1'b0;
                  if (job_cnt != '0) begin
                     state_q <= S_RUN;
                  end else begin
                     state_q     <= S_DONE;
                     res_valid_q <= 1'b1;
                  end
               end
            end
            S_RUN: begin
`ifdef CORDIC_CTRL_OV_STOP_EN
               if (any_ov) begin
                  // The overflowing step is dropped: state keeps its pre-step value.
                  ov_q        <= core_ov;
                  ov_iter_q   <= {1'b0, iter_q};
                  state_q     <= S_DONE;
                  res_valid_q <= 1'b1;
               end else begin
                  x_q <= i_core_x;
                  y_q <= i_core_y;
                  z_q <= i_core_z;
                  if (last_step) begin
                     state_q     <= S_DONE;
                     res_valid_q <= 1'b1;
                  end else begin
                     iter_q <= iter_nxt;
                  end
               end
`else
               x_q  <= i_core_x;
               y_q  <= i_core_y;
               z_q  <= i_core_z;
               ov_q <= ov_q | core_ov;
               // Sticky flags still clear means this is the first overflowing step.
               if (any_ov && (ov_q == 3'b000)) begin
                  ov_iter_q <= {1'b0, iter_q};
               end
               if (last_step) begin
                  state_q     <= S_DONE;
                  res_valid_q <= 1'b1;
               end else begin
                  iter_q <= iter_nxt;
               end
`endif
            end
            S_DONE: begin
               // A job offered in this cycle is not taken; ready rises only after the handshake.
               if (i_res_ready) begin
                  state_q     <= S_IDLE;
                  res_valid_q <= 1'b0;
                  job_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               res_valid_q <= 1'b0;
               job_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign o_job_ready   = job_ready_q;
   assign o_core_x      = x_q;
   assign o_core_y      = y_q;
   assign o_core_z      = z_q;
   assign o_core_iter   = iter_q;
   assign o_core_system = system_q;
   assign o_core_mode   = mode_q;
   assign o_res_valid   = res_valid_q;
   assign o_res_x       = x_q;
   assign o_res_y       = y_q;
   assign o_res_z       = z_q;
   assign o_res_ov      = ov_q;
   assign o_res_ov_iter = ov_iter_q;

endmodule

// File: tb/tb_cordic_controller.sv
// Purpose : Self-checking bench for cordic_controller with a behavioural cordic core attached.
// Latency : Results checked for exact arrival cycle, values, overflow info and handshake rules.
// Backpressure: Exercises result stalls with job requests offered during the stall and handshake.
module tb_cordic_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_job_valid;
   logic        o_job_ready;
   logic [31:0] i_job_x, i_job_y, i_job_z;
   logic        i_job_system, i_job_mode;
   logic [4:0]  i_job_num_iter;
   logic [31:0] o_core_x, o_core_y, o_core_z;
   logic [4:0]  o_core_iter;
   logic        o_core_system, o_core_mode;
   logic [31:0] i_core_x, i_core_y, i_core_z;
   logic        i_core_x_ov, i_core_y_ov, i_core_z_ov;
   logic        o_res_valid;
   logic        i_res_ready;
   logic [31:0] o_res_x, o_res_y, o_res_z;
   logic [2:0]  o_res_ov;
   logic [5:0]  o_res_ov_iter;

   int checks   = 0;
   int failures = 0;

   // Iteration at which the core model raises each overflow flag (-1 = never).
   int fx_it = -1, fy_it = -1, fz_it = -1;
   logic [31:0] last_x, last_y;

   // Angle tables, z scaled by 2^29 (radians).
   longint atan_t [0:31];
   longint atanh_t[0:31];

   cordic_controller dut (
      .clk(clk), .rst_n(rst_n),
      .i_job_valid(i_job_valid), .o_job_ready(o_job_ready),
      .i_job_x(i_job_x), .i_job_y(i_job_y), .i_job_z(i_job_z),
      .i_job_system(i_job_system), .i_job_mode(i_job_mode), .i_job_num_iter(i_job_num_iter),
      .o_core_x(o_core_x), .o_core_y(o_core_y), .o_core_z(o_core_z),
      .o_core_iter(o_core_iter), .o_core_system(o_core_system), .o_core_mode(o_core_mode),
      .i_core_x(i_core_x), .i_core_y(i_core_y), .i_core_z(i_core_z),
      .i_core_x_ov(i_core_x_ov), .i_core_y_ov(i_core_y_ov), .i_core_z_ov(i_core_z_ov),
      .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
      .o_res_x(o_res_x), .o_res_y(o_res_y), .o_res_z(o_res_z),
      .o_res_ov(o_res_ov), .o_res_ov_iter(o_res_ov_iter)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // One cordic micro-rotation with rounded shifts; hyperbolic uses shift it+1.
   function automatic void core_step(input logic [31:0] x, y, z, input int it,
                                     input logic sys, mode,
                                     output logic [31:0] xn, yn, zn);
      int s;
      longint xl, yl, zl, xs, ys, rnd, ang;
      logic dpos;
      s = sys ? it : it + 1;
      if (s > 31) s = 31;
      xl  = longint'($signed(x));
      yl  = longint'($signed(y));
      zl  = longint'($signed(z));
      rnd = (s > 0) ? (longint'(1) <<< (s - 1)) : longint'(0);
      xs  = (xl + rnd) >>> s;
      ys  = (yl + rnd) >>> s;
      ang = sys ? atan_t[s] : atanh_t[s];
      dpos = mode ? (zl >= 0) : (yl < 0);
      if (sys) xn = 32'(dpos ? xl - ys : xl + ys);
      else     xn = 32'(dpos ? xl + ys : xl - ys);
      yn = 32'(dpos ? yl + xs : yl - xs);
      zn = 32'(dpos ? zl - ang : zl + ang);
   endfunction

   always_comb begin
      core_step(o_core_x, o_core_y, o_core_z, int'(o_core_iter), o_core_system, o_core_mode,
                i_core_x, i_core_y, i_core_z);
   end
   assign i_core_x_ov = (int'(o_core_iter) == fx_it);
   assign i_core_y_ov = (int'(o_core_iter) == fy_it);
   assign i_core_z_ov = (int'(o_core_iter) == fz_it);

   // Expected outcome of a job: apply the core min(n,30) times, tracking overflow.
   task automatic ref_job(input logic [31:0] x, y, z, input logic sys, mode,
                          input int n, fx, fy, fz,
                          output logic [31:0] rx, ry, rz, output logic [2:0] rov,
                          output logic [5:0] rit, output int lat, output int maxit);
      int cnt;
      logic [2:0] fl;
      logic [31:0] tx, ty, tz;
      cnt = (n > 30) ? 30 : n;
      rx = x; ry = y; rz = z;
      rov = 3'b000; rit = 6'h3F;
      lat = cnt + 1; maxit = cnt - 1;
      for (int i = 0; i < cnt; i++) begin
         fl = {i == fx, i == fy, i == fz};
`ifdef CORDIC_CTRL_OV_STOP_EN
         if (fl != 3'b000) begin
            rov = fl; rit = 6'(i); lat = i + 2; maxit = i;
            break;
         end
`else
         if (fl != 3'b000 && rit == 6'h3F) rit = 6'(i);
         rov = rov | fl;
`endif
         core_step(rx, ry, rz, i, sys, mode, tx, ty, tz);
         rx = tx; ry = ty; rz = tz;
      end
   endtask

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_job(input string nm, input logic [31:0] x, y, z, input logic sys, mode,
                          input int n, fx, fy, fz, hold, input logic jv_in_hs);
      logic [31:0] ex, ey, ez;
      logic [2:0]  eov;
      logic [5:0]  eit;
      int elat, emx, lat, mx, w;
      ref_job(x, y, z, sys, mode, n, fx, fy, fz, ex, ey, ez, eov, eit, elat, emx);
      fx_it = fx; fy_it = fy; fz_it = fz;
      w = 0;
      while (!o_job_ready && w < 50) begin tick(); w++; end
      if (!o_job_ready) begin chk({nm, "_ready_wait"}, 0, 1); return; end
      i_job_x = x; i_job_y = y; i_job_z = z;
      i_job_system = sys; i_job_mode = mode; i_job_num_iter = 5'(n);
      i_job_valid = 1'b1;
      tick();
      i_job_valid = 1'b0;
      i_job_x = $urandom; i_job_y = $urandom; i_job_z = $urandom;
      i_job_num_iter = 5'($urandom);
      lat = 1; mx = -1;
      while (!o_res_valid && lat < 64) begin
         if (int'(o_core_iter) > mx) mx = int'(o_core_iter);
         tick();
         lat++;
      end
      chk({nm, "_latency"}, lat, elat);
      chk({nm, "_max_iter"}, mx, emx);
      if (!o_res_valid) return;
      chk({nm, "_res_xyz"}, {o_res_x, o_res_y, o_res_z}, {ex, ey, ez});
      chk({nm, "_res_ov"}, {o_res_ov, o_res_ov_iter}, {eov, eit});
      chk({nm, "_busy"}, o_job_ready, 0);
      last_x = o_res_x; last_y = o_res_y;
      for (int h = 0; h < hold; h++) begin
         i_res_ready = 1'b0;
         i_job_valid = 1'($urandom);
         tick();
         chk({nm, "_stall_hold"},
             {o_res_valid, o_job_ready, o_res_x, o_res_y, o_res_z, o_res_ov, o_res_ov_iter},
             {1'b1, 1'b0, ex, ey, ez, eov, eit});
      end
      i_res_ready = 1'b1;
      i_job_valid = jv_in_hs;
      tick();
      i_res_ready = 1'b0;
      i_job_valid = 1'b0;
      chk({nm, "_release"}, {o_res_valid, o_job_ready}, {1'b0, 1'b1});
   endtask

   initial begin
      int n, fx, fy, fz, w;
      longint dx, dy;
      for (int s = 0; s < 32; s++) begin
         real t;
         t = 2.0 ** (-s);
         atan_t[s]  = longint'($rtoi($atan(t) * (2.0 ** 29) + 0.5));
         atanh_t[s] = (s == 0) ? longint'(0)
                      : longint'($rtoi(0.5 * $ln((1.0 + t) / (1.0 - t)) * (2.0 ** 29) + 0.5));
      end
      rst_n = 1'b1;
      i_job_valid = 1'b0; i_res_ready = 1'b0;
      i_job_x = '0; i_job_y = '0; i_job_z = '0;
      i_job_system = 1'b0; i_job_mode = 1'b0; i_job_num_iter = '0;
      #2 rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      chk("reset_state",
          {o_job_ready, o_res_valid, o_res_ov, o_res_ov_iter, o_core_iter, o_res_x},
          {1'b1, 1'b0, 3'b000, 6'h3F, 5'd0, 32'd0});

      // 45 degree rotation of (1/K, 0): x and y converge to cos45 (x/y scaled 2^30).
      run_job("rot45", 32'h26DD_3B6A, 32'd0, 32'd421657428, 1'b1, 1'b1, 30, -1, -1, -1, 0, 1'b0);
      dx = longint'($signed(last_x)) - 64'sh2D41_3CCD;
      dy = longint'($signed(last_y)) - 64'sh2D41_3CCD;
      chk("rot45_close", {(dx <= 64 && dx >= -64), (dy <= 64 && dy >= -64)}, 2'b11);

      run_job("cnt0", 32'h1234_5678, 32'h0BAD_F00D, 32'h0000_1000, 1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b0);
      run_job("cnt31", $urandom, $urandom, $urandom, 1'b0, 1'b1, 31, -1, -1, -1, 0, 1'b0);
      run_job("ovy7", $urandom, $urandom, $urandom, 1'b1, 1'b1, 30, -1, 7, -1, 0, 1'b0);
      run_job("stall10", $urandom, $urandom, $urandom, 1'b1, 1'b0, 12, 3, -1, 9, 10, 1'b1);

      // Reset in the middle of a job.
      fx_it = -1; fy_it = -1; fz_it = -1;
      i_job_x = $urandom; i_job_y = $urandom; i_job_z = $urandom;
      i_job_system = 1'b1; i_job_mode = 1'b1; i_job_num_iter = 5'd30;
      i_job_valid = 1'b1;
      tick();
      i_job_valid = 1'b0;
      w = 0;
      while (o_core_iter != 5'd12 && w < 40) begin tick(); w++; end
      chk("mid_reset_reach12", o_core_iter, 5'd12);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_reset_async",
          {o_job_ready, o_res_valid, o_res_ov, o_res_ov_iter, o_core_iter, o_res_x},
          {1'b1, 1'b0, 3'b000, 6'h3F, 5'd0, 32'd0});
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      chk("mid_reset_no_result", {o_res_valid, o_job_ready}, {1'b0, 1'b1});
      run_job("after_reset", $urandom, $urandom, $urandom, 1'b1, 1'b1, 30, -1, -1, -1, 0, 1'b0);

      for (int j = 0; j < 20; j++) begin
         n  = $urandom_range(0, 31);
         fx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : -1;
         fy = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : -1;
         fz = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : -1;
         run_job("rand", $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom), n,
                 fx, fy, fz, $urandom_range(0, 3), 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
